// File: rtl/tpu_pkg.sv
// Shared constants and FSM encoding for the systolic array feeder.
package tpu_pkg;

  localparam int DATA_SIZE = 8;
  localparam int N         = 4;
  localparam int ACC_W     = 2 * DATA_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    FEED,
    FLUSH,
    CAPTURE,
    DRAIN
  } state_e;

endpackage

// File: rtl/skew_gen.sv
// Diagonal skew of stored A rows / B columns for feed step t (combinational).
module skew_gen
  import tpu_pkg::*;
#(
  parameter int DW = DATA_SIZE,
  parameter int TW = 4
) (
  input  logic [TW-1:0]     t_i,
  input  logic [N*N*DW-1:0] a_rows_i,
  input  logic [N*N*DW-1:0] b_cols_i,
  output logic [N*DW-1:0]   sa_a_o,
  output logic [N*DW-1:0]   sa_b_o
);

  // Both stores use slot (lane*N + k): A[lane][k] and B[k][lane] share the same index form.
  always_comb begin
    sa_a_o = '0;
    sa_b_o = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t_i) == i + k) begin
          sa_a_o[i*DW +: DW] = a_rows_i[(i*N+k)*DW +: DW];
          sa_b_o[i*DW +: DW] = b_cols_i[(i*N+k)*DW +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Loads A/B, clears and feeds the 4x4 output-stationary array, then returns C row by row.
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [N*DATA_SIZE-1:0]     ld_a_row,
  input  logic [N*DATA_SIZE-1:0]     ld_b_col,
  output logic                       sa_rst,
  output logic [N*DATA_SIZE-1:0]     sa_a,
  output logic [N*DATA_SIZE-1:0]     sa_b,
  input  logic [N*N*2*DATA_SIZE-1:0] sa_c,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [N*2*DATA_SIZE-1:0]   res_row,
  output logic                       busy
);

  localparam int RW = 2 * DATA_SIZE;
  localparam int CW = $clog2(FLUSH_CYCLES + 2*N);

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [N*N*DATA_SIZE-1:0]   a_q, b_q;
  logic [N*N*RW-1:0]          bank_q;
  logic [N*DATA_SIZE-1:0]     sa_a_q, sa_b_q, skew_a, skew_b;
  logic                       ld_ready_q, sa_rst_q, res_valid_q, busy_q;
  logic                       ld_hs, res_hs;

  assign ld_hs  = ld_valid && ld_ready_q;
  assign res_hs = res_valid_q && res_ready;

  // cnt is the beat index k in LOAD, step t in FEED, flush count, and row r in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (ld_hs) begin
        state_d = LOAD;
        cnt_d   = CW'(1);
      end
      LOAD: if (ld_hs) begin
        if (cnt_q == CW'(N-1)) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CLEAR: begin
        state_d = FEED;
        cnt_d   = '0;
      end
      FEED: if (cnt_q == CW'(2*N-2)) begin
        state_d = FLUSH;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      FLUSH: if (cnt_q == CW'(FLUSH_CYCLES-1)) begin
        state_d = CAPTURE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      CAPTURE: begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
      DRAIN: if (res_hs) begin
        if (cnt_q == CW'(N-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Skew is taken from the next step so the operands register in with their FEED cycle.
  skew_gen #(
    .DW(DATA_SIZE),
    .TW(CW)
  ) u_skew (
    .t_i      (cnt_d),
    .a_rows_i (a_q),
    .b_cols_i (b_q),
    .sa_a_o   (skew_a),
    .sa_b_o   (skew_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      bank_q      <= '0;
      sa_a_q      <= '0;
      sa_b_q      <= '0;
      ld_ready_q  <= 1'b0;
      sa_rst_q    <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_ready_q  <= (state_d == IDLE) || (state_d == LOAD);
      sa_rst_q    <= (state_d == CLEAR);
      res_valid_q <= (state_d == DRAIN);
      busy_q      <= (state_d != IDLE);
      sa_a_q      <= (state_d == FEED) ? skew_a : '0;
      sa_b_q      <= (state_d == FEED) ? skew_b : '0;
      if (ld_hs) begin
        a_q[cnt_q*N*DATA_SIZE +: N*DATA_SIZE] <= ld_a_row;
        b_q[cnt_q*N*DATA_SIZE +: N*DATA_SIZE] <= ld_b_col;
      end
      if (state_q == CAPTURE) begin
        bank_q <= sa_c;
      end
    end
  end

  assign ld_ready  = ld_ready_q;
  assign sa_rst    = sa_rst_q;
  assign sa_a      = sa_a_q;
  assign sa_b      = sa_b_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign res_row   = res_valid_q ? bank_q[cnt_q*N*RW +: N*RW] : '0;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder driving a behavioural 4x4 output-stationary PE array.
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_a_row, ld_b_col;
  logic        sa_rst;
  logic [31:0] sa_a, sa_b;
  logic [255:0] sa_c;
  logic        res_valid, res_ready;
  logic [63:0] res_row;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int A[4][4], B[4][4], E[4][4];
  logic [63:0] got[4];
  int sa_rst_cnt = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_SIZE(8), .FLUSH_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_a_row(ld_a_row), .ld_b_col(ld_b_col), .sa_rst(sa_rst),
    .sa_a(sa_a), .sa_b(sa_b), .sa_c(sa_c), .res_valid(res_valid),
    .res_ready(res_ready), .res_row(res_row), .busy(busy)
  );

  // Array model: a flows right, b flows down, each PE accumulates a*b mod 2^16.
  logic [7:0]  ar[4][4], br[4][4];
  logic [15:0] acc[4][4];

  always @(posedge clk) begin
    logic [7:0] ain, bin;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 0) ain = sa_a[i*8 +: 8];
        else        ain = ar[i][j-1];
        if (i == 0) bin = sa_b[j*8 +: 8];
        else        bin = br[i-1][j];
        if (rst || sa_rst) begin
          ar[i][j]  <= '0;
          br[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          ar[i][j]  <= ain;
          br[i][j]  <= bin;
          acc[i][j] <= acc[i][j] + 16'(ain) * 16'(bin);
        end
      end
    end
    if (!rst && sa_rst) sa_rst_cnt <= sa_rst_cnt + 1;
  end

  always_comb begin
    sa_c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        sa_c[(i*4+j)*16 +: 16] = acc[i][j];
  end

  function automatic logic [63:0] erow(input int r);
    logic [63:0] v;
    for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(E[r][j]);
    return v;
  endfunction

  // gap_mode 0: gapless; otherwise beat k waits k idle cycles first.
  task automatic load_job(input int gap_mode, output bit to);
    int n;
    to = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (gap_mode != 0) repeat (k) @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        ld_a_row[m*8 +: 8] = 8'(A[k][m]);
        ld_b_col[m*8 +: 8] = 8'(B[m][k]);
      end
      ld_valid = 1'b1;
      n = 0;
      while (ld_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) to = 1'b1;
      @(negedge clk);
      ld_valid = 1'b0;
    end
  endtask

  task automatic drain_job(output bit to);
    int n;
    to = 1'b0;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (res_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin to = 1'b1; return; end
      got[r] = res_row;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ld_ready !== 1'b0 || sa_rst !== 1'b1 || sa_a !== '0 || sa_b !== '0 ||
        res_valid !== 1'b0 || res_row !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b sarst=%b a=%h b=%h rv=%b row=%h busy=%b want 0 1 0 0 0 0 0",
               ld_ready, sa_rst, sa_a, sa_b, res_valid, res_row, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b1 || sa_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got rdy=%b sarst=%b busy=%b want 1 0 0", ld_ready, sa_rst, busy);
    end
  endtask

  task automatic test_identity;
    bit to;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = (i == j) ? 1 : 0;
        B[i][j] = 4*i + j + 1;
        E[i][j] = 4*i + j + 1;
      end
    load_job(0, to);
    drain_job(to);
    checks++;
    if (to) begin errors++; $display("FAIL identity_timeout got timeout want 4 beats"); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== erow(r)) begin
        errors++;
        $display("FAIL identity_row%0d got %h want %h", r, got[r], erow(r));
      end
    end
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL identity_end got busy=%b rv=%b want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_wrap;
    bit to;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = 255; B[i][j] = 255; E[i][j] = 63492;
      end
    load_job(0, to);
    drain_job(to);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== erow(r)) begin
        errors++;
        $display("FAIL wrap_row%0d got %h want %h", r, got[r], erow(r));
      end
    end
  endtask

  task automatic test_skew;
    bit to;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = 10*i + j;
        B[i][j] = (i == j) ? 1 : 0;
        E[i][j] = 10*i + j;
      end
    load_job(0, to);
    checks++;
    if (sa_rst !== 1'b1) begin errors++; $display("FAIL skew_clear got sa_rst=%b want 1", sa_rst); end
    repeat (3) @(negedge clk);
    checks++;
    if (sa_a !== 32'h00140B02 || sa_b !== 32'h00000100) begin
      errors++;
      $display("FAIL skew_t2 got a=%h b=%h want 00140b02 00000100", sa_a, sa_b);
    end
    checks++;
    if (ld_ready !== 1'b0 || sa_rst !== 1'b0) begin
      errors++;
      $display("FAIL skew_feed_ctl got rdy=%b sarst=%b want 0 0", ld_ready, sa_rst);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (sa_a !== 32'h21000000 || sa_b !== 32'h01000000) begin
      errors++;
      $display("FAIL skew_t6 got a=%h b=%h want 21000000 01000000", sa_a, sa_b);
    end
    @(negedge clk);
    checks++;
    if (sa_a !== '0 || sa_b !== '0) begin
      errors++;
      $display("FAIL skew_flush got a=%h b=%h want 0 0", sa_a, sa_b);
    end
    drain_job(to);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== erow(r)) begin
        errors++;
        $display("FAIL skew_row%0d got %h want %h", r, got[r], erow(r));
      end
    end
  endtask

  task automatic test_stall;
    bit to;
    int n, beats, cyc;
    logic [63:0] held;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = (i == j) ? 1 : 0;
        B[i][j] = 4*i + j + 1;
        E[i][j] = 4*i + j + 1;
      end
    load_job(0, to);
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL stall_wait got timeout want res_valid"); end
    held = res_row;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_row !== held) begin
        errors++;
        $display("FAIL stall_hold got rv=%b row=%h want 1 %h", res_valid, res_row, held);
      end
    end
    beats = 0;
    cyc = 0;
    while (beats < 4 && cyc < 100) begin
      res_ready = (cyc % 2 == 0);
      if (res_valid === 1'b1 && res_ready) begin got[beats] = res_row; beats++; end
      @(negedge clk);
      cyc++;
    end
    res_ready = 1'b0;
    checks++;
    if (beats != 4) begin errors++; $display("FAIL stall_beats got %0d want 4", beats); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== erow(r)) begin
        errors++;
        $display("FAIL stall_row%0d got %h want %h", r, got[r], erow(r));
      end
    end
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end got busy=%b rv=%b want 0 0", busy, res_valid);
    end
  endtask

  task automatic test_back_to_back;
    bit to;
    int c0;
    for (int job = 0; job < 2; job++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          if (job == 0) begin
            A[i][j] = (i == j) ? 1 : 0; B[i][j] = 4*i + j + 1; E[i][j] = 4*i + j + 1;
          end else begin
            A[i][j] = (i == j) ? 2 : 0; B[i][j] = j + 1; E[i][j] = 2*(j + 1);
          end
        end
      c0 = sa_rst_cnt;
      load_job(0, to);
      drain_job(to);
      checks++;
      if (sa_rst_cnt - c0 != 1) begin
        errors++;
        $display("FAIL b2b_sa_rst_job%0d got %0d pulses want 1", job, sa_rst_cnt - c0);
      end
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (got[r] !== erow(r)) begin
          errors++;
          $display("FAIL b2b_job%0d_row%0d got %h want %h", job, r, got[r], erow(r));
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit to, seen;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin A[i][j] = 255; B[i][j] = 255; end
    load_job(0, to);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b0 || sa_rst !== 1'b1 || sa_a !== '0 || sa_b !== '0 ||
        res_valid !== 1'b0 || res_row !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got rdy=%b sarst=%b a=%h b=%h rv=%b row=%h busy=%b want 0 1 0 0 0 0 0",
               ld_ready, sa_rst, sa_a, sa_b, res_valid, res_row, busy);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_abort got activity after reset want idle"); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = (i == j) ? 3 : 0; B[i][j] = i + 1; E[i][j] = 3*(i + 1);
      end
    load_job(0, to);
    drain_job(to);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (got[r] !== erow(r)) begin
        errors++;
        $display("FAIL midrst_row%0d got %h want %h", r, got[r], erow(r));
      end
    end
  endtask

  task automatic test_gaps;
    bit to;
    for (int mode = 1; mode >= 0; mode--) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          A[i][j] = 4*i + j + 1; B[i][j] = (i == j) ? 2 : 0; E[i][j] = 2*(4*i + j + 1);
        end
      load_job(mode, to);
      ld_a_row = 32'hDEADBEEF;
      ld_b_col = 32'hCAFEF00D;
      ld_valid = 1'b1;
      repeat (8) begin
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b0) begin
          errors++;
          $display("FAIL gaps_feed_ready got %b want 0", ld_ready);
        end
      end
      ld_valid = 1'b0;
      drain_job(to);
      for (int r = 0; r < 4; r++) begin
        checks++;
        if (got[r] !== erow(r)) begin
          errors++;
          $display("FAIL gaps_mode%0d_row%0d got %h want %h", mode, r, got[r], erow(r));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ld_valid = 1'b0;
    ld_a_row = '0;
    ld_b_col = '0;
    res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_identity();
    test_wrap();
    test_skew();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1, "watchdog");
  end

endmodule
